// File: rtl/rd_ctrl_pkg.sv
// Shared types and sizing helpers for the burst read controller.
// Combinational helpers only; no latency or flow control of their own.
package rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  function automatic logic [31:0] words_from_bytes(input logic [31:0] len,
                                                   input logic [31:0] bytes);
    return (len / bytes) + 32'((len % bytes) != 32'd0);
  endfunction

  function automatic logic [31:0] burst_len(input logic [31:0] words_left,
                                            input logic [31:0] max);
    return (words_left < max) ? words_left : max;
  endfunction

endpackage

// File: rtl/rd_ctrl_burst_cnt.sv
// Beat tracker: flags the last beat of the current burst and of the packet, same cycle as the beat.
// Loaded on burst accept, decremented per beat; no backpressure (beats are never refused).
module rd_ctrl_burst_cnt
  import rd_ctrl_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BURST_W-1:0] burst_words,
  input  logic [LEN_W-1:0]   pkt_words,
  input  logic               beat,
  output logic               burst_last,
  output logic               packet_last
);

  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]   pkt_rem_q, pkt_rem_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_rem_d  = pkt_rem_q;
    if (load) begin
      beat_cnt_d = burst_words;
      pkt_rem_d  = pkt_words;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q - 1'b1;
      pkt_rem_d  = pkt_rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
      pkt_rem_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      pkt_rem_q  <= pkt_rem_d;
    end
  end

  assign burst_last  = beat && (beat_cnt_q == BURST_W'(1));
  assign packet_last = beat && (pkt_rem_q == LEN_W'(1));

endmodule

// File: rtl/rd_ctrl_burst.sv
// Descriptor-driven Avalon-MM burst reader into the capture FIFO; FIFO write 1 cycle after readdatavalid.
// Requests gated by fifo_almost_full, held under waitrequest; RD_CTRL_BURST_STATS_EN adds stat counters.
module rd_ctrl_burst
  import rd_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            pkt_addr,
  input  logic [LEN_W-1:0]             pkt_len,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            avm_address,
  output logic                         avm_read,
  output logic [$clog2(MAX_BURST):0]   avm_burstcount,
  input  logic                         avm_waitrequest,
  input  logic [DATA_W-1:0]            avm_readdata,
  input  logic                         avm_readdatavalid,
  input  logic                         fifo_almost_full,
  output logic                         fifo_wr,
  output logic [DATA_W-1:0]            fifo_data,
  output logic                         fifo_eop
`ifdef RD_CTRL_BURST_STATS_EN
  ,
  output logic [31:0]                  stat_pkts,
  output logic [31:0]                  stat_words,
  output logic [31:0]                  stat_stalls
`endif
);

  localparam int BYTES   = DATA_W / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  rd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   words_left_q, words_left_d;
  logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
  logic               avm_read_q, avm_read_d;
  logic [BURST_W-1:0] burstcount_q, burstcount_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic [DATA_W-1:0]  fifo_data_q, fifo_data_d;
  logic               fifo_eop_q, fifo_eop_d;

  logic [LEN_W-1:0]   words_init;
  logic [BURST_W-1:0] next_burst;
  logic               cnt_load;
  logic               beat;
  logic               burst_last;
  logic               packet_last;

  assign words_init = LEN_W'(words_from_bytes(32'(pkt_len), 32'(BYTES)));
  assign next_burst = BURST_W'(burst_len(32'(words_left_q), 32'(MAX_BURST)));
  // Beats outside DATA belong to an aborted burst and are dropped.
  assign beat       = (state_q == DATA) && avm_readdatavalid;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_left_d  = words_left_q;
    avm_address_d = avm_address_q;
    avm_read_d    = avm_read_q;
    burstcount_d  = burstcount_q;
    done_d        = 1'b0;
    fifo_wr_d     = 1'b0;
    fifo_data_d   = fifo_data_q;
    fifo_eop_d    = 1'b0;
    cnt_load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = pkt_addr;
          words_left_d = words_init;
          state_d      = (words_init == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (!avm_read_q) begin
          if (!fifo_almost_full) begin
            avm_read_d    = 1'b1;
            avm_address_d = addr_q;
            burstcount_d  = next_burst;
          end
        end else if (!avm_waitrequest) begin
          avm_read_d   = 1'b0;
          addr_d       = addr_q + (ADDR_W'(burstcount_q) << BYTE_SH);
          words_left_d = words_left_q - LEN_W'(burstcount_q);
          cnt_load     = 1'b1;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          fifo_wr_d   = 1'b1;
          fifo_data_d = avm_readdata;
          fifo_eop_d  = packet_last;
          if (burst_last) begin
            state_d = (words_left_q != '0) ? REQ : DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      words_left_q  <= '0;
      avm_address_q <= '0;
      avm_read_q    <= 1'b0;
      burstcount_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fifo_wr_q     <= 1'b0;
      fifo_data_q   <= '0;
      fifo_eop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      words_left_q  <= words_left_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      burstcount_q  <= burstcount_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_data_q   <= fifo_data_d;
      fifo_eop_q    <= fifo_eop_d;
    end
  end

  // pkt_words takes the pre-subtraction count so packet_last covers this burst too.
  rd_ctrl_burst_cnt #(
    .LEN_W   (LEN_W),
    .BURST_W (BURST_W)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .load        (cnt_load),
    .burst_words (burstcount_q),
    .pkt_words   (words_left_q),
    .beat        (beat),
    .burst_last  (burst_last),
    .packet_last (packet_last)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_burstcount = burstcount_q;
  assign fifo_wr        = fifo_wr_q;
  assign fifo_data      = fifo_data_q;
  assign fifo_eop       = fifo_eop_q;

`ifdef RD_CTRL_BURST_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d;
  logic [31:0] stat_words_q, stat_words_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;
  logic        stall;

  assign stall = (state_q == REQ) &&
                 ((!avm_read_q && fifo_almost_full) || (avm_read_q && avm_waitrequest));

  always_comb begin
    stat_pkts_d   = stat_pkts_q;
    stat_words_d  = stat_words_q;
    stat_stalls_d = stat_stalls_q;
    if (done_d && (stat_pkts_q != 32'hFFFF_FFFF)) stat_pkts_d = stat_pkts_q + 32'd1;
    if (fifo_wr_d && (stat_words_q != 32'hFFFF_FFFF)) stat_words_d = stat_words_q + 32'd1;
    if (stall && (stat_stalls_q != 32'hFFFF_FFFF)) stat_stalls_d = stat_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkts_q   <= '0;
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_pkts_q   <= stat_pkts_d;
      stat_words_q  <= stat_words_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_pkts   = stat_pkts_q;
  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_rd_ctrl_burst.sv
// Directed bench for rd_ctrl_burst with a single-outstanding Avalon slave and FIFO monitor.
module tb_rd_ctrl_burst;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pkt_addr;
  logic [15:0] pkt_len;
  logic        busy;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        fifo_almost_full;
  logic        fifo_wr;
  logic [31:0] fifo_data;
  logic        fifo_eop;
`ifdef RD_CTRL_BURST_STATS_EN
  logic [31:0] stat_pkts;
  logic [31:0] stat_words;
  logic [31:0] stat_stalls;
`endif

  rd_ctrl_burst dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .pkt_addr          (pkt_addr),
    .pkt_len           (pkt_len),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_wr           (fifo_wr),
    .fifo_data         (fifo_data),
    .fifo_eop          (fifo_eop)
`ifdef RD_CTRL_BURST_STATS_EN
    ,
    .stat_pkts         (stat_pkts),
    .stat_words        (stat_words),
    .stat_stalls       (stat_stalls)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int fails     = 0;

  // Slave/monitor bookkeeping, written only by the slave process.
  int          acc_cnt    = 0;
  int          beats_sent = 0;
  int          wr_cnt     = 0;
  int          eop_cnt    = 0;
  int          eop_at     = 0;
  int          done_cnt   = 0;
  int          read_cyc   = 0;
  int          wait_cyc   = 0;
  int          unstable   = 0;
  int          pending    = 0;
  int          cur_wait   = 0;
  logic [31:0] rd_addr    = 32'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic [3:0]  prev_bc    = 4'h0;
  logic [31:0] acc_addr_q[$];
  int          acc_bc_q[$];
  logic [31:0] wr_data_q[$];

  // Written only by the test tasks.
  int stall_idx    = -1;
  int stall_target = 0;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    forever begin
      @(negedge clk);
      if (fifo_wr) begin
        wr_cnt++;
        wr_data_q.push_back(fifo_data);
        if (fifo_eop) begin
          eop_cnt++;
          eop_at = wr_cnt;
        end
      end
      if (done) done_cnt++;
      if (avm_read) read_cyc++;
      if (prev_stall && (!avm_read || avm_address !== prev_addr || avm_burstcount !== prev_bc))
        unstable++;
      if (pending > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rd_addr;
        rd_addr           = rd_addr + 32'd4;
        pending--;
        beats_sent++;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEAD_BEEF;
      end
      prev_stall = 1'b0;
      if (avm_read) begin
        if (acc_cnt == stall_idx && cur_wait < stall_target) begin
          avm_waitrequest = 1'b1;
          cur_wait++;
          wait_cyc++;
          prev_stall = 1'b1;
          prev_addr  = avm_address;
          prev_bc    = avm_burstcount;
        end else begin
          avm_waitrequest = 1'b0;
          cur_wait = 0;
          acc_cnt++;
          acc_addr_q.push_back(avm_address);
          acc_bc_q.push_back(int'(avm_burstcount));
          rd_addr = avm_address;
          pending = int'(avm_burstcount);
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] a, input logic [15:0] l);
    pkt_addr = a;
    pkt_len  = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({busy, done, avm_read, fifo_wr, fifo_eop} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, avm_read, fifo_wr, fifo_eop});
    end
    tests_run++;
    if ({avm_address, avm_burstcount, fifo_data} !== 68'h0) begin
      fails++;
      $display("FAIL reset_data: addr %h bc %0d data %h expected all 0", avm_address, avm_burstcount, fifo_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_bursts();
    int a0 = acc_cnt, w0 = wr_cnt, e0 = eop_cnt, d0 = done_cnt;
    bit ok;
`ifdef RD_CTRL_BURST_STATS_EN
    logic [31:0] p0 = stat_pkts, sw0 = stat_words;
`endif
    go(32'h1000, 16'd64);
    wait_done(300, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL t1_done_timeout: no done within 300 cycles"); end
    tests_run++;
    if (acc_cnt - a0 != 2) begin fails++; $display("FAIL t1_bursts: got %0d expected 2", acc_cnt - a0); end
    tests_run++;
    if (acc_addr_q[a0] !== 32'h1000 || acc_addr_q[a0+1] !== 32'h1020) begin
      fails++;
      $display("FAIL t1_addr: got %h,%h expected 00001000,00001020", acc_addr_q[a0], acc_addr_q[a0+1]);
    end
    tests_run++;
    if (acc_bc_q[a0] != 8 || acc_bc_q[a0+1] != 8) begin
      fails++;
      $display("FAIL t1_bc: got %0d,%0d expected 8,8", acc_bc_q[a0], acc_bc_q[a0+1]);
    end
    tests_run++;
    if (wr_cnt - w0 != 16) begin fails++; $display("FAIL t1_writes: got %0d expected 16", wr_cnt - w0); end
    tests_run++;
    if (eop_cnt - e0 != 1 || eop_at - w0 != 16) begin
      fails++;
      $display("FAIL t1_eop: got count %0d at %0d expected 1 at 16", eop_cnt - e0, eop_at - w0);
    end
    tests_run++;
    if (wr_data_q[w0] !== 32'h1000 || wr_data_q[w0+15] !== 32'h103C) begin
      fails++;
      $display("FAIL t1_data: got %h..%h expected 00001000..0000103c", wr_data_q[w0], wr_data_q[w0+15]);
    end
    tick();
    tick();
    tests_run++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL t1_done_pulse: got %0d pulses expected 1", done_cnt - d0); end
`ifdef RD_CTRL_BURST_STATS_EN
    tests_run++;
    if (stat_pkts - p0 != 32'd1 || stat_words - sw0 != 32'd16) begin
      fails++;
      $display("FAIL t1_stats: got pkts %0d words %0d expected 1,16", stat_pkts - p0, stat_words - sw0);
    end
`endif
  endtask

  task automatic test_short_and_zero();
    int a0 = acc_cnt, w0 = wr_cnt, e0 = eop_cnt, r0;
    bit ok;
    go(32'h2000, 16'd13);
    wait_done(100, ok);
    tests_run++;
    if (!ok || acc_cnt - a0 != 1 || acc_bc_q[a0] != 4) begin
      fails++;
      $display("FAIL t2_len13_burst: done %0d bursts %0d bc %0d expected 1,1,4", ok, acc_cnt - a0, acc_bc_q[a0]);
    end
    tests_run++;
    if (wr_cnt - w0 != 4 || eop_cnt - e0 != 1 || eop_at - w0 != 4 || wr_data_q[w0+3] !== 32'h200C) begin
      fails++;
      $display("FAIL t2_len13_fifo: writes %0d eop@%0d last %h expected 4, 4, 0000200c",
               wr_cnt - w0, eop_at - w0, wr_data_q[w0+3]);
    end
    tick();
    a0 = acc_cnt; w0 = wr_cnt; r0 = read_cyc;
    go(32'h7000, 16'd0);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL t2_len0_cycle1: done %b busy %b expected 0,1", done, busy);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL t2_len0_cycle2: done %b busy %b expected 1,0", done, busy);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || read_cyc != r0 || wr_cnt != w0 || acc_cnt != a0) begin
      fails++;
      $display("FAIL t2_len0_quiet: done %b reads %0d writes %0d expected 0,0,0", done, read_cyc - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_almost_full();
    int a0 = acc_cnt, w0 = wr_cnt, early = 0;
    bit ok;
`ifdef RD_CTRL_BURST_STATS_EN
    logic [31:0] s0 = stat_stalls;
`endif
    fifo_almost_full = 1'b1;
    go(32'h3000, 16'd32);
    for (int i = 0; i < 20; i++) begin
      if (avm_read !== 1'b0) early++;
      tick();
    end
    fifo_almost_full = 1'b0;
    if (avm_read !== 1'b0) early++;
    tests_run++;
    if (early != 0) begin fails++; $display("FAIL t3_gated: got %0d read cycles expected 0", early); end
    tick();
    tests_run++;
    if (avm_read !== 1'b1 || avm_address !== 32'h3000 || avm_burstcount !== 4'd8) begin
      fails++;
      $display("FAIL t3_issue: read %b addr %h bc %0d expected 1, 00003000, 8", avm_read, avm_address, avm_burstcount);
    end
    wait_done(100, ok);
    tests_run++;
    if (!ok || acc_cnt - a0 != 1 || wr_cnt - w0 != 8) begin
      fails++;
      $display("FAIL t3_complete: done %0d bursts %0d writes %0d expected 1,1,8", ok, acc_cnt - a0, wr_cnt - w0);
    end
`ifdef RD_CTRL_BURST_STATS_EN
    tests_run++;
    if (stat_stalls - s0 != 32'd20) begin
      fails++;
      $display("FAIL t3_stalls: got %0d expected 20", stat_stalls - s0);
    end
`endif
  endtask

  task automatic test_waitrequest();
    int a0 = acc_cnt, w0 = wr_cnt, wc0 = wait_cyc, u0 = unstable;
    bit ok;
    stall_idx    = acc_cnt;
    stall_target = 5;
    go(32'h4000, 16'd32);
    wait_done(100, ok);
    stall_target = 0;
    tests_run++;
    if (wait_cyc - wc0 != 5 || unstable != u0) begin
      fails++;
      $display("FAIL t4_hold: stall cycles %0d unstable %0d expected 5,0", wait_cyc - wc0, unstable - u0);
    end
    tests_run++;
    if (!ok || acc_cnt - a0 != 1 || acc_addr_q[a0] !== 32'h4000 || acc_bc_q[a0] != 8 || wr_cnt - w0 != 8) begin
      fails++;
      $display("FAIL t4_accept: done %0d bursts %0d addr %h bc %0d writes %0d expected 1,1,00004000,8,8",
               ok, acc_cnt - a0, acc_addr_q[a0], acc_bc_q[a0], wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w0 = wr_cnt, d0 = done_cnt, b0 = beats_sent;
    bit hit = 1'b0;
    go(32'h8000, 16'd32);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_cnt - w0 == 3) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin fails++; $display("FAIL t5_three_beats: got %0d writes expected 3", wr_cnt - w0); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || avm_read !== 1'b0 || fifo_wr !== 1'b0) begin
      fails++;
      $display("FAIL t5_idle: busy %b read %b wr %b expected 0,0,0", busy, avm_read, fifo_wr);
    end
    for (int i = 0; i < 15; i++) tick();
    tests_run++;
    if (wr_cnt - w0 != 3 || done_cnt != d0 || beats_sent - b0 != 8) begin
      fails++;
      $display("FAIL t5_drop: writes %0d done %0d beats %0d expected 3,0,8", wr_cnt - w0, done_cnt - d0, beats_sent - b0);
    end
  endtask

  task automatic test_back_to_back();
    int a0 = acc_cnt, w0 = wr_cnt, e0;
    bit ok;
    go(32'hFFFF_FFE0, 16'd64);
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL t6_busy: got %b expected 1", busy); end
    go(32'h5000, 16'd4);
    wait_done(300, ok);
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (!ok || acc_cnt - a0 != 2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL t6_ignored: done %0d bursts %0d busy %b expected 1,2,0", ok, acc_cnt - a0, busy);
    end
    tests_run++;
    if (acc_addr_q[a0] !== 32'hFFFF_FFE0 || acc_addr_q[a0+1] !== 32'h0 || wr_data_q[w0+15] !== 32'h1C) begin
      fails++;
      $display("FAIL t6_wrap: got %h,%h last %h expected ffffffe0,00000000,0000001c",
               acc_addr_q[a0], acc_addr_q[a0+1], wr_data_q[w0+15]);
    end
    a0 = acc_cnt; w0 = wr_cnt; e0 = eop_cnt;
    go(32'h6000, 16'd4);
    wait_done(100, ok);
    tests_run++;
    if (!ok || acc_cnt - a0 != 1 || acc_addr_q[a0] !== 32'h6000 || acc_bc_q[a0] != 1) begin
      fails++;
      $display("FAIL t6_restart: done %0d bursts %0d addr %h bc %0d expected 1,1,00006000,1",
               ok, acc_cnt - a0, acc_addr_q[a0], acc_bc_q[a0]);
    end
    tests_run++;
    if (wr_cnt - w0 != 1 || eop_cnt - e0 != 1 || wr_data_q[w0] !== 32'h6000) begin
      fails++;
      $display("FAIL t6_single: writes %0d eops %0d data %h expected 1,1,00006000", wr_cnt - w0, eop_cnt - e0, wr_data_q[w0]);
    end
  endtask

  initial begin
    reset            = 1'b1;
    start            = 1'b0;
    pkt_addr         = 32'h0;
    pkt_len          = 16'h0;
    fifo_almost_full = 1'b0;
    test_reset();
    test_two_bursts();
    test_short_and_zero();
    test_almost_full();
    test_waitrequest();
    test_reset_mid_burst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
